regfile_dump_reader: RTL and testbench

//   Debug-side reader for the 32x32 CPU register file. On a start pulse it walks an inclusive index

---
 rtl/regfile_dump_reader.sv | 176 +++++++++++++++++
 tb/tb_regfile_dump_reader.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks an inclusive register index range two at a time and streams the values out.
// Optional checksum word at the end of the dump when REGDUMP_CSUM_EN is defined.
module regfile_dump_reader #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IDX_W-1:0]  first_idx,
  input  logic [IDX_W-1:0]  last_idx,
  output logic [IDX_W-1:0]  rf_raindex,
  output logic [IDX_W-1:0]  rf_rbindex,
  input  logic [DATA_W-1:0] rf_outa,
  input  logic [DATA_W-1:0] rf_outb,
  output logic [DATA_W-1:0] dout_data,
  output logic [IDX_W-1:0]  dout_index,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last,
  output logic              dout_csum,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_SEND_A = 3'd2,
    S_SEND_B = 3'd3,
`ifdef REGDUMP_CSUM_EN
    S_CSUM   = 3'd4,
`endif
    S_DONE   = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0]  cur, end_idx;
  logic [DATA_W-1:0] buf_a, buf_b;
  logic              pair_b;
  logic [IDX_W-1:0]  cur_p1, first_p1;
  logic              b_is_end;
  logic              xfer;
  logic              finish;

  assign cur_p1   = cur + IDX_W'(1);
  assign first_p1 = first_idx + IDX_W'(1);
  assign b_is_end = (cur_p1 == end_idx);
  assign xfer     = dout_valid & dout_ready;

`ifdef REGDUMP_CSUM_EN
  logic [DATA_W-1:0] csum;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    finish     = 1'b0;
    dout_valid = 1'b0;
    dout_data  = '0;
    dout_index = '0;
    dout_last  = 1'b0;
    dout_csum  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: state_nxt = S_SEND_A;
      S_SEND_A: begin
        dout_valid = 1'b1;
        dout_data  = buf_a;
        dout_index = cur;
`ifndef REGDUMP_CSUM_EN
        dout_last  = ~pair_b;
`endif
        if (xfer) begin
          if (pair_b) state_nxt = S_SEND_B;
          else        finish    = 1'b1;
        end
      end
      S_SEND_B: begin
        dout_valid = 1'b1;
        dout_data  = buf_b;
        dout_index = cur_p1;
`ifndef REGDUMP_CSUM_EN
        dout_last  = b_is_end;
`endif
        if (xfer) begin
          if (b_is_end) finish    = 1'b1;
          else          state_nxt = S_FETCH;
        end
      end
`ifdef REGDUMP_CSUM_EN
      S_CSUM: begin
        dout_valid = 1'b1;
        dout_data  = csum;
        dout_csum  = 1'b1;
        dout_last  = 1'b1;
        if (xfer) state_nxt = S_DONE;
      end
`endif
      S_DONE: begin
        busy      = 1'b0;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
    if (finish) begin
`ifdef REGDUMP_CSUM_EN
      state_nxt = S_CSUM;
`else
      state_nxt = S_DONE;
`endif
    end
  end

  // Read-port indices are only updated on entry to FETCH so they are stable for the whole fetch cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur        <= '0;
      end_idx    <= '0;
      buf_a      <= '0;
      buf_b      <= '0;
      pair_b     <= 1'b0;
      rf_raindex <= '0;
      rf_rbindex <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          cur        <= first_idx;
          end_idx    <= last_idx;
          rf_raindex <= first_idx;
          rf_rbindex <= first_p1;
        end
        S_FETCH: begin
          buf_a  <= rf_outa;
          buf_b  <= rf_outb;
          pair_b <= (cur != end_idx);
        end
        S_SEND_B: if (xfer && !b_is_end) begin
          cur        <= cur + IDX_W'(2);
          rf_raindex <= cur + IDX_W'(2);
          rf_rbindex <= cur + IDX_W'(3);
        end
        default: ;
      endcase
    end
  end

`ifdef REGDUMP_CSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum <= '0;
    end else if (state == S_IDLE && start) begin
      csum <= '0;
    end else if (xfer && state == S_SEND_A) begin
      csum <= csum ^ buf_a;
    end else if (xfer && state == S_SEND_B) begin
      csum <= csum ^ buf_b;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard testbench for regfile_dump_reader: directed dumps, expected words queued, monitor pops on transfer.
`timescale 1ns/1ps
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  first_idx = '0, last_idx = '0;
  logic [4:0]  rf_raindex, rf_rbindex;
  logic [31:0] rf_outa, rf_outb;
  logic [31:0] dout_data;
  logic [4:0]  dout_index;
  logic        dout_valid, dout_ready, dout_last, dout_csum, busy, done;

  logic [31:0] rf [32];
  assign rf_outa = rf[rf_raindex];
  assign rf_outb = rf[rf_rbindex];

  regfile_dump_reader #(.DATA_W(32), .IDX_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .first_idx(first_idx), .last_idx(last_idx),
    .rf_raindex(rf_raindex), .rf_rbindex(rf_rbindex), .rf_outa(rf_outa), .rf_outb(rf_outb),
    .dout_data(dout_data), .dout_index(dout_index), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_last(dout_last), .dout_csum(dout_csum),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
    logic        csum;
  } word_t;

  word_t exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Ready driver: 0 = always ready, 1 = backpressure pattern, 2 = never ready
  int ready_mode = 0;
  initial begin
    automatic logic [7:0] pat = 8'b1011_0001;
    automatic int cyc = 0;
    dout_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       dout_ready = pat[cyc % 8];
        2:       dout_ready = 1'b0;
        default: dout_ready = 1'b1;
      endcase
      cyc++;
    end
  end

  // Monitor: compare on every transfer and check stability while stalled
  word_t held;
  logic  hold_pending = 1'b0;
  always @(negedge clk) begin
    word_t w, e;
    w = '{idx: dout_index, data: dout_data, last: dout_last, csum: dout_csum};
    if (rst) begin
      hold_pending = 1'b0;
    end else if (dout_valid) begin
      if (hold_pending) chk("stall_stable", 64'(w), 64'(held));
      if (dout_ready) begin
        hold_pending = 1'b0;
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 64'(w), 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          chk("word", 64'(w), 64'(e));
        end
      end else begin
        hold_pending = 1'b1;
        held = w;
      end
    end else if (hold_pending) begin
      chk("valid_dropped", 64'(dout_valid), 64'd1);
      hold_pending = 1'b0;
    end
  end

  function automatic logic [31:0] model(input logic [4:0] i);
    return (i == 5'd0) ? 32'd0 : 32'h100 + 32'(i);
  endfunction

  task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int mode, input bit mid_start);
    logic [4:0]  n_minus1, idx, fp1;
    logic [31:0] x;
    bit          got;
    n_minus1 = l - f;
    x = '0;
    for (int k = 0; k <= int'(n_minus1); k++) begin
      idx = f + 5'(k);
      x   = x ^ model(idx);
`ifdef REGDUMP_CSUM_EN
      exp_q.push_back('{idx: idx, data: model(idx), last: 1'b0, csum: 1'b0});
`else
      exp_q.push_back('{idx: idx, data: model(idx), last: (k == int'(n_minus1)), csum: 1'b0});
`endif
    end
`ifdef REGDUMP_CSUM_EN
    exp_q.push_back('{idx: 5'd0, data: x, last: 1'b1, csum: 1'b1});
`endif
    ready_mode = mode;
    @(posedge clk); #1;
    first_idx = f; last_idx = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    fp1 = f + 5'd1;
    chk("fetch_busy", 64'(busy), 64'd1);
    chk("fetch_valid", 64'(dout_valid), 64'd0);
    chk("fetch_raindex", 64'(rf_raindex), 64'(f));
    chk("fetch_rbindex", 64'(rf_rbindex), 64'(fp1));
    @(posedge clk); #1;
    chk("first_valid", 64'(dout_valid), 64'd1);
    got = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk);
      if (mid_start && c == 4) begin
        first_idx = 5'd7; last_idx = 5'd7; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) got = 1'b1;
    end
    start = 1'b0;
    chk("done_seen", 64'(got), 64'd1);
    chk("done_busy_low", 64'(busy), 64'd0);
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    ready_mode = 0;
  endtask

  initial begin
    bit seen;
    for (int i = 0; i < 32; i++) rf[i] = model(5'(i));
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(dout_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_raindex", 64'(rf_raindex), 64'd0);
    chk("rst_rbindex", 64'(rf_rbindex), 64'd0);
    chk("rst_outs", 64'({dout_data, dout_index, dout_last, dout_csum}), 64'd0);
    rst = 1'b0;

    run_dump(5'd0,  5'd31, 0, 1'b0);
    run_dump(5'd30, 5'd1,  0, 1'b0);
    run_dump(5'd31, 5'd0,  0, 1'b0);
    run_dump(5'd5,  5'd5,  0, 1'b0);
    run_dump(5'd10, 5'd17, 1, 1'b1);
    run_dump(5'd1,  5'd3,  0, 1'b0);

    // Reset in the middle of a stalled dump
    ready_mode = 2;
    @(posedge clk); #1;
    first_idx = 5'd0; last_idx = 5'd31; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (dout_valid) seen = 1'b1;
    end
    chk("abort_valid_before", 64'(seen), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("abort_valid", 64'(dout_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ready_mode = 0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done || dout_valid || busy) seen = 1'b1;
    end
    chk("abort_quiet", 64'(seen), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
